alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_arbiter_alu.sv | 28 ++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code constants and the default operand width.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOR = 3'b011,
    OP_OR  = 3'b100
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: add/sub/and/or/nor with a zero flag.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU with a single-entry response buffer.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and an offered response holds
  // all its fields stable until it is taken.
  logic              buf_free;
  logic              pick1;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;

  // Draining and refilling in the same cycle keeps one op per cycle.
  assign buf_free = !rsp_valid_q || rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick1 = !req0_valid;
`else
  logic rr_q;
  logic rr_d;

  assign pick1 = !req0_valid || (req1_valid && rr_q);

  always_comb begin
    rr_d = rr_q;
    if (grant0)      rr_d = 1'b1;
    else if (grant1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  assign grant0     = buf_free && req0_valid && !pick1;
  assign grant1     = buf_free && req1_valid && pick1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_a  = pick1 ? req1_a  : req0_a;
  assign alu_b  = pick1 ? req1_b  : req0_b;
  assign alu_op = pick1 ? req1_op : req0_op;

  alu_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Payload keeps its last value after a drain; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (grant0 || grant1) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= pick1;
      rsp_result_q <= alu_result;
      rsp_zero_q   <= alu_zero;
    end else if (rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized plus directed bench for alu_arbiter against a behavioural model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [W-1:0] rsp_result;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic         m_valid;
  logic         m_id;
  logic [W-1:0] m_res;
  logic         m_zero;
  int           m_rr;
  logic [W:0]   exp_q[$];

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned r;
    case (int'(op))
      0:       r = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
      1:       r = (longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000;
      2:       r = longint'(a & b);
      4:       r = longint'(a | b);
      3:       r = longint'(~(a | b));
      default: r = 0;
    endcase
    return {(r == 0), r[W-1:0]};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 1'b0;
    m_res   = '0;
    m_zero  = 1'b0;
    m_rr    = 0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
  endtask

  // one cycle: check outputs, drive inputs, check grants, advance the model
  task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                      input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                      input bit rr_in);
    int g;
    logic [W:0] r;
    logic [W:0] e;
    @(negedge clk);
    check("rsp_valid",  {31'd0, rsp_valid}, {31'd0, m_valid});
    check("rsp_id",     {31'd0, rsp_id},    {31'd0, m_id});
    check("rsp_result", rsp_result,         m_res);
    check("rsp_zero",   {31'd0, rsp_zero},  {31'd0, m_zero});
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr_in;
    #1;
    g = -1;
    if (!m_valid || rr_in) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (v0 && v1) g = 0;
`else
      if (v0 && v1) g = m_rr;
`endif
      else if (v0) g = 0;
      else if (v1) g = 1;
    end
    check("req0_ready", {31'd0, req0_ready}, {31'd0, (g == 0)});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, (g == 1)});
    if (m_valid && rr_in) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_id",     {31'd0, rsp_id}, {31'd0, e[W]});
        check("sb_result", rsp_result,      e[W-1:0]);
      end else begin
        check("sb_empty", 32'd0, 32'd1);
      end
    end
    if (g >= 0) begin
      r = (g == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
      m_valid = 1'b1;
      m_id    = (g == 1);
      m_res   = r[W-1:0];
      m_zero  = r[W];
      exp_q.push_back({m_id, m_res});
`ifndef ALU_ARB_FIXED_PRIO_EN
      m_rr = 1 - g;
`endif
    end else if (rr_in) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid",  {31'd0, rsp_valid}, 32'd0);
    check("reset_result", rsp_result,         32'd0);
    rst_n = 1'b1;

    // add 5+7
    step(1, 32'd5, 32'd7, OP_ADD, 0, '0, '0, OP_ADD, 1);
    after_edge();
    check("add_valid",  {31'd0, rsp_valid}, 32'd1);
    check("add_id",     {31'd0, rsp_id},    32'd0);
    check("add_result", rsp_result,         32'd12);
    check("add_zero",   {31'd0, rsp_zero},  32'd0);

    // 0-1 wraps
    step(1, 32'd0, 32'd1, OP_SUB, 0, '0, '0, OP_ADD, 1);
    after_edge();
    check("sub_wrap_result", rsp_result,        32'hFFFF_FFFF);
    check("sub_wrap_zero",   {31'd0, rsp_zero}, 32'd0);

    // undefined op from requester 1
    step(0, '0, '0, OP_ADD, 1, 32'd3, 32'd4, 3'b111, 1);
    after_edge();
    check("badop_id",     {31'd0, rsp_id},   32'd1);
    check("badop_result", rsp_result,        32'd0);
    check("badop_zero",   {31'd0, rsp_zero}, 32'd1);

    // sustained contention
    for (int i = 0; i < 4; i++) begin
      step(1, 32'd9, 32'd9, OP_SUB, 1, 32'hF0, 32'h0F, OP_OR, 1);
      after_edge();
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("contend_id",     {31'd0, rsp_id}, 32'd0);
      check("contend_result", rsp_result,      32'd0);
`else
      check("contend_id",     {31'd0, rsp_id}, i % 2);
      check("contend_result", rsp_result,      (i % 2) ? 32'hFF : 32'd0);
      check("contend_zero",   {31'd0, rsp_zero}, (i % 2) ? 32'd0 : 32'd1);
`endif
    end

    // backpressure for 4 cycles, then drain+grant in one cycle
    step(1, 32'd1, 32'd2, OP_ADD, 1, 32'd6, 32'd3, OP_AND, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, $urandom, $urandom, OP_ADD, 1, $urandom, $urandom, OP_OR, 0);
      check("bp_ready", {31'd0, req0_ready | req1_ready}, 32'd0);
    end
    step(1, 32'd10, 32'd20, OP_ADD, 1, 32'd6, 32'd3, OP_AND, 1);
    check("bp_regrant", {31'd0, req0_ready | req1_ready}, 32'd1);

    // reset while a response is buffered
    step(1, 32'd4, 32'd4, OP_ADD, 0, '0, '0, OP_ADD, 1);
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("rst_mid_valid",  {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_id",     {31'd0, rsp_id},    32'd0);
    check("rst_mid_result", rsp_result,         32'd0);
    check("rst_mid_zero",   {31'd0, rsp_zero},  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'd1, 32'd1, OP_AND, 1, 32'd2, 32'd2, OP_AND, 1);
    check("rst_first_r0", {31'd0, req0_ready}, 32'd1);
    after_edge();
    check("rst_first_id", {31'd0, rsp_id}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ra0 = $urandom; ra1 = $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      step($urandom_range(0, 3) != 0, ra0, rb0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, ra1, rb1, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0);
    end

    // drain
    for (int i = 0; i < 3; i++) step(0, '0, '0, OP_ADD, 0, '0, '0, OP_ADD, 1);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
